// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared types and constants for the serial add sequencer slice.
//   state_t        : sequencer FSM state (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  : default operand/result width in bits
// Optional feature macro used elsewhere in the slice: SERIAL_ADD_SUB_EN
// -----------------------------------------------------------------------------
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_add_pkg

// File: rtl/serial_add_sequencer_if.sv
// -----------------------------------------------------------------------------
// serial_add_sequencer_if
// Operand/result handshake bundle for serial_add_sequencer.
//   in_valid/in_ready   : operand handshake (producer -> sequencer)
//   a_in, b_in          : WIDTH-bit operands
//   sub_in              : subtract select (only when SERIAL_ADD_SUB_EN is defined)
//   out_valid/out_ready : result handshake (sequencer -> consumer)
//   sum_out, carry_out  : WIDTH-bit result and carry out of the MSB
// Modports: master = producer/consumer side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface serial_add_sequencer_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub_in;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;

`ifdef SERIAL_ADD_SUB_EN
  modport master (
    output in_valid, a_in, b_in, sub_in, out_ready,
    input  in_ready, out_valid, sum_out, carry_out
  );

  modport slave (
    input  in_valid, a_in, b_in, sub_in, out_ready,
    output in_ready, out_valid, sum_out, carry_out
  );
`else
  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, sum_out, carry_out
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, sum_out, carry_out
  );
`endif

endinterface : serial_add_sequencer_if

// File: rtl/serial_adder_bit.sv
// -----------------------------------------------------------------------------
// serial_adder_bit
// One-bit full-adder slice with its own carry flop.
//   clk, rst      : clock, synchronous active-high reset (carry -> 0)
//   a, b          : current operand bits
//   clear         : load carry with clear_val this edge (start of an operation)
//   clear_val     : 0 for add, 1 for subtract (two's complement +1)
//   en            : advance carry to carry_next this edge
//   sum           : a ^ b ^ carry
//   carry_next    : carry produced by this bit
//   carry         : current registered carry
// -----------------------------------------------------------------------------
module serial_adder_bit (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic clear,
  input  logic clear_val,
  input  logic en,
  output logic sum,
  output logic carry_next,
  output logic carry
);

  logic carry_r;
  logic half_s;

  assign half_s     = a ^ b;
  assign sum        = half_s ^ carry_r;
  assign carry_next = (a & b) | (half_s & carry_r);
  assign carry      = carry_r;

  // Carry flop: reset wins, then start-of-operation load, then per-bit advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_r <= 1'b0;
    end else if (clear) begin
      carry_r <= clear_val;
    end else if (en) begin
      carry_r <= carry_next;
    end else begin
      carry_r <= carry_r;
    end
  end

endmodule : serial_adder_bit

// File: rtl/serial_add_sequencer.sv
// -----------------------------------------------------------------------------
// serial_add_sequencer
// Adds two WIDTH-bit operands LSB-first through a single serial_adder_bit,
// one bit per clock, with valid/ready handshakes on both sides.
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset, priority over every handshake
//   bus  : serial_add_sequencer_if.slave (operands in, result out)
// Result {carry_out, sum_out} = a_in + b_in, first valid WIDTH edges after
// the accepting edge; held in DONE until out_ready, kept afterwards in IDLE.
// Optional: SERIAL_ADD_SUB_EN adds bus.sub_in; when set, B is inverted and
// the carry starts at 1 so the result is a_in - b_in (carry_out=1: no borrow).
// -----------------------------------------------------------------------------
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  serial_add_sequencer_if.slave bus
);

  if (WIDTH < 2) begin : g_width_check
    $error("serial_add_sequencer: WIDTH must be 2 or more");
  end

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-2:0] sum_sh_r;
  logic [WIDTH-1:0] sum_out_r;
  logic             carry_out_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic             accept_s;
  logic             run_s;
  logic             clear_val_s;
  logic             sum_bit_s;
  logic             carry_next_s;
  logic             carry_s;
  logic [WIDTH-1:0] sum_cat_s;
  logic [WIDTH-1:0] b_load_s;

  // In IDLE in_ready_r is always 1, so the state test alone is the handshake.
  assign accept_s = (state_r == IDLE) & bus.in_valid;
  assign run_s    = (state_r == RUN);

`ifdef SERIAL_ADD_SUB_EN
  assign clear_val_s = bus.sub_in;
  assign b_load_s    = bus.sub_in ? ~bus.b_in : bus.b_in;
`else
  assign clear_val_s = 1'b0;
  assign b_load_s    = bus.b_in;
`endif

  // Partial sum with the new bit prepended; on the last bit this is the result.
  assign sum_cat_s = {sum_bit_s, sum_sh_r};

  serial_adder_bit u_bit (
    .clk        (clk),
    .rst        (rst),
    .a          (a_sh_r[0]),
    .b          (b_sh_r[0]),
    .clear      (accept_s),
    .clear_val  (clear_val_s),
    .en         (run_s),
    .sum        (sum_bit_s),
    .carry_next (carry_next_s),
    .carry      (carry_s)
  );

  // Sequencer FSM with shift registers, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      sum_sh_r    <= '0;
      sum_out_r   <= '0;
      carry_out_r <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_sh_r     <= bus.a_in;
            b_sh_r     <= b_load_s;
            sum_sh_r   <= '0;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end else begin
            in_ready_r <= 1'b1;
            state_r    <= IDLE;
          end
        end
        RUN: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          sum_sh_r <= sum_cat_s[WIDTH-1:1];
          cnt_r    <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            sum_out_r   <= sum_cat_s;
            carry_out_r <= carry_next_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum_out   = sum_out_r;
  assign bus.carry_out = carry_out_r;

endmodule : serial_add_sequencer

// File: tb/tb_serial_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sequencer
// Directed bench for serial_add_sequencer (WIDTH=8). Inputs are driven on the
// falling edge or just after the rising edge; outputs are sampled on the
// falling edge. Subtract vectors run only when SERIAL_ADD_SUB_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_add_sequencer;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  serial_add_sequencer_if #(.WIDTH(W)) bus ();

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands while in_ready is high and return just after the accepting edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic sub, input string tag);
    @(negedge clk);
    check_eq({tag, ".in_ready_before"}, 32'(bus.in_ready), 32'd1);
    bus.a_in     = a;
    bus.b_in     = b;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub_in   = sub;
`else
    if (sub) $display("note: subtract requested without SERIAL_ADD_SUB_EN");
`endif
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Called right after the accepting edge; counts edges until out_valid.
  task automatic wait_result(input logic [7:0] es, input logic ec, input string tag);
    int lat;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.out_valid) break;
    end
    check_eq({tag, ".latency"}, 32'(lat), 32'd8);
    check_eq({tag, ".sum"}, 32'(bus.sum_out), 32'(es));
    check_eq({tag, ".carry"}, 32'(bus.carry_out), 32'(ec));
    check_eq({tag, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
  endtask

  // At a falling edge with out_valid high: stall for hold cycles, then drain.
  task automatic drain(input int hold, input logic [7:0] es, input logic ec, input string tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      check_eq({tag, ".hold_sum"}, 32'(bus.sum_out), 32'(es));
      check_eq({tag, ".hold_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, ".drained_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, ".drained_ready"}, 32'(bus.in_ready), 32'd1);
    check_eq({tag, ".kept_sum"}, 32'(bus.sum_out), 32'(es));
    check_eq({tag, ".kept_carry"}, 32'(bus.carry_out), 32'(ec));
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a_in      = 8'h00;
    bus.b_in      = 8'h00;
    bus.out_ready = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub_in    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset.in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("reset.sum", 32'(bus.sum_out), 32'd0);
    check_eq("reset.carry", 32'(bus.carry_out), 32'd0);

    // Basic add
    start_op(8'h5A, 8'h3C, 1'b0, "add5a3c");
    wait_result(8'h96, 1'b0, "add5a3c");
    drain(0, 8'h96, 1'b0, "add5a3c");

    // Carry out of MSB, then carry must not leak into the next operation
    start_op(8'hFF, 8'h01, 1'b0, "addff01");
    wait_result(8'h00, 1'b1, "addff01");
    drain(0, 8'h00, 1'b1, "addff01");
    start_op(8'h00, 8'h00, 1'b0, "add0000");
    wait_result(8'h00, 1'b0, "add0000");
    drain(0, 8'h00, 1'b0, "add0000");

    // Back-pressure: result held for 5 stalled cycles
    start_op(8'h12, 8'h34, 1'b0, "stall");
    wait_result(8'h46, 1'b0, "stall");
    drain(5, 8'h46, 1'b0, "stall");

    // New operand offered during RUN must wait for in_ready
    start_op(8'h11, 8'h22, 1'b0, "busy1");
    bus.a_in     = 8'hAA;
    bus.b_in     = 8'h55;
    bus.in_valid = 1'b1;
    wait_result(8'h33, 1'b0, "busy1");
    drain(0, 8'h33, 1'b0, "busy1");
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_result(8'hFF, 1'b0, "busy2");
    drain(0, 8'hFF, 1'b0, "busy2");

    // Mid-operation reset at cnt==3
    start_op(8'h0F, 8'h01, 1'b0, "abort");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort.in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("abort.out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("abort.sum", 32'(bus.sum_out), 32'd0);
    check_eq("abort.carry", 32'(bus.carry_out), 32'd0);
    repeat (8) @(negedge clk);
    check_eq("abort.no_result", 32'(bus.out_valid), 32'd0);
    start_op(8'h01, 8'h01, 1'b0, "after_abort");
    wait_result(8'h02, 1'b0, "after_abort");
    drain(0, 8'h02, 1'b0, "after_abort");

`ifdef SERIAL_ADD_SUB_EN
    start_op(8'h10, 8'h20, 1'b1, "sub1020");
    wait_result(8'hF0, 1'b0, "sub1020");
    drain(0, 8'hF0, 1'b0, "sub1020");
    start_op(8'h20, 8'h10, 1'b1, "sub2010");
    wait_result(8'h10, 1'b1, "sub2010");
    drain(0, 8'h10, 1'b1, "sub2010");
    start_op(8'h7F, 8'h01, 1'b0, "add_after_sub");
    wait_result(8'h80, 1'b0, "add_after_sub");
    drain(0, 8'h80, 1'b0, "add_after_sub");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_add_sequencer
